// File: rtl/btn_scanner_pkg.sv
// Shared definitions for the front-panel button scanner: serial bit positions
// of each button in the shift-register chain and the scan FSM states.
package btn_scanner_pkg;

    localparam int NUM_BTNS           = 9;
    localparam int BTN_IDX_A          = 0;
    localparam int BTN_IDX_B          = 1;
    localparam int BTN_IDX_SEL        = 2;
    localparam int BTN_IDX_START      = 3;
    localparam int BTN_IDX_DPAD_RIGHT = 4;
    localparam int BTN_IDX_DPAD_LEFT  = 5;
    localparam int BTN_IDX_DPAD_UP    = 6;
    localparam int BTN_IDX_DPAD_DOWN  = 7;
    localparam int BTN_IDX_MENU       = 8;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_SETTLE,
        ST_SHIFT_HI,
        ST_SHIFT_LO,
        ST_DONE,
        ST_GAP
    } scan_state_e;

endpackage

// File: rtl/btn_debounce.sv
// One button's debouncer: the output follows the raw sample only after
// DEBOUNCE_SCANS consecutive scans disagree with it.
module btn_debounce #(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic pclk,
    input  logic reset_n,
    input  logic raw_i,
    input  logic upd_i,
    output logic btn_o
);

    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_SCANS - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          btn_q, btn_d;

    always_comb begin
        cnt_d = cnt_q;
        btn_d = btn_q;
        if (upd_i) begin
            if (raw_i == btn_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                btn_d = raw_i;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            btn_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            btn_q <= btn_d;
        end
    end

    assign btn_o = btn_q;

endmodule

// File: rtl/btn_scanner.sv
// Scans the nine front-panel buttons out of a 74HC165-style chain and
// drives debounced, active-high button levels in the pclk domain.
module btn_scanner
    import btn_scanner_pkg::*;
#(
    parameter int CLK_DIV        = 8,
    parameter int NBITS          = 16,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int SCAN_GAP       = 1024
) (
    input  logic pclk,
    input  logic reset_n,
    output logic BTN_SR_LD_N,
    output logic BTN_SR_CLK,
    input  logic BTN_SR_DATA,
    output logic BTN_A,
    output logic BTN_B,
    output logic BTN_SEL,
    output logic BTN_START,
    output logic BTN_DPAD_RIGHT,
    output logic BTN_DPAD_LEFT,
    output logic BTN_DPAD_UP,
    output logic BTN_DPAD_DOWN,
    output logic BTN_MENU,
    output logic scan_done
);

    localparam int PH_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(NBITS);
    localparam int GAP_W = (SCAN_GAP > 1) ? $clog2(SCAN_GAP) : 1;
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NBITS - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SCAN_GAP - 1);

    scan_state_e         state_q, state_d;
    logic [PH_W-1:0]     phase_q, phase_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [NBITS-1:0]    raw_q, raw_d;
    logic                ld_n_q, ld_n_d;
    logic                sclk_q, sclk_d;
    logic                done_q, done_d;
    logic                phase_end;
    logic [NUM_BTNS-1:0] btn;

    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        gap_d     = gap_q;
        raw_d     = raw_q;
        phase_end = (phase_q == PH_LAST);
        phase_d   = phase_end ? '0 : phase_q + PH_W'(1);
        case (state_q)
            ST_LOAD: begin
                if (phase_end) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (phase_end) begin
                    raw_d[0] = ~BTN_SR_DATA;
                    bit_d    = BIT_W'(1);
                    state_d  = ST_SHIFT_HI;
                end
            end
            ST_SHIFT_HI: begin
                if (phase_end) state_d = ST_SHIFT_LO;
            end
            ST_SHIFT_LO: begin
                if (phase_end) begin
                    raw_d[bit_q] = ~BTN_SR_DATA;
                    if (bit_q == BIT_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        state_d = ST_SHIFT_HI;
                    end
                end
            end
            ST_DONE: begin
                phase_d = '0;
                bit_d   = '0;
                gap_d   = '0;
                state_d = ST_GAP;
            end
            ST_GAP: begin
                phase_d = '0;
                if (gap_q == GAP_LAST) state_d = ST_LOAD;
                else                   gap_d   = gap_q + GAP_W'(1);
            end
            default: begin
                phase_d = '0;
                state_d = ST_LOAD;
            end
        endcase
    end

    // Chain strobes are registered from the next state so they change only on pclk edges.
    assign ld_n_d = (state_d != ST_LOAD);
    assign sclk_d = (state_d == ST_SHIFT_HI);
    assign done_d = (state_d == ST_DONE);

    // Reset parks the FSM at the end of GAP so the first edge after release enters LOAD.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_GAP;
            phase_q <= '0;
            bit_q   <= '0;
            gap_q   <= GAP_LAST;
            raw_q   <= '0;
            ld_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            raw_q   <= raw_d;
            ld_n_q  <= ld_n_d;
            sclk_q  <= sclk_d;
            done_q  <= done_d;
        end
    end

    // raw_d includes the bit captured on the DONE edge, so short chains debounce the final bit too.
    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_deb
        btn_debounce #(
            .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
        ) u_deb (
            .pclk   (pclk),
            .reset_n(reset_n),
            .raw_i  (raw_d[i]),
            .upd_i  (done_d),
            .btn_o  (btn[i])
        );
    end

    assign BTN_SR_LD_N    = ld_n_q;
    assign BTN_SR_CLK     = sclk_q;
    assign scan_done      = done_q;
    assign BTN_A          = btn[BTN_IDX_A];
    assign BTN_B          = btn[BTN_IDX_B];
    assign BTN_SEL        = btn[BTN_IDX_SEL];
    assign BTN_START      = btn[BTN_IDX_START];
    assign BTN_DPAD_RIGHT = btn[BTN_IDX_DPAD_RIGHT];
    assign BTN_DPAD_LEFT  = btn[BTN_IDX_DPAD_LEFT];
    assign BTN_DPAD_UP    = btn[BTN_IDX_DPAD_UP];
    assign BTN_DPAD_DOWN  = btn[BTN_IDX_DPAD_DOWN];
    assign BTN_MENU       = btn[BTN_IDX_MENU];

endmodule

// File: tb/tb_btn_scanner.sv
// Bench for btn_scanner: behavioural 74HC165 chain, a scan-history debounce
// model, a per-scan vector table and directed reset/timing sequences.
module tb_btn_scanner;

    localparam int CLK_DIV    = 8;
    localparam int NBITS      = 16;
    localparam int DS         = 4;
    localparam int SCAN_GAP   = 1024;
    localparam int UW         = NBITS - 9;
    localparam int FIRST_DONE = 2 * CLK_DIV * NBITS;
    localparam int PERIOD     = 2 * CLK_DIV * NBITS + 1 + SCAN_GAP;

    localparam logic [8:0] PA  = 9'h001;
    localparam logic [8:0] PB  = 9'h002;
    localparam logic [8:0] PST = 9'h008;
    localparam logic [8:0] PUP = 9'h040;
    localparam logic [8:0] PMN = 9'h100;

    typedef struct packed {
        logic [8:0] pressed;
        logic [8:0] exp;
    } vec_t;

    logic pclk = 1'b0;
    logic reset_n;
    logic BTN_SR_LD_N, BTN_SR_CLK, BTN_SR_DATA;
    logic BTN_A, BTN_B, BTN_SEL, BTN_START, BTN_DPAD_RIGHT;
    logic BTN_DPAD_LEFT, BTN_DPAD_UP, BTN_DPAD_DOWN, BTN_MENU, scan_done;
    logic [8:0] btns;

    int checks = 0;
    int failures = 0;

    always #5 pclk = ~pclk;

    btn_scanner #(
        .CLK_DIV(CLK_DIV), .NBITS(NBITS), .DEBOUNCE_SCANS(DS), .SCAN_GAP(SCAN_GAP)
    ) dut (
        .pclk(pclk), .reset_n(reset_n),
        .BTN_SR_LD_N(BTN_SR_LD_N), .BTN_SR_CLK(BTN_SR_CLK), .BTN_SR_DATA(BTN_SR_DATA),
        .BTN_A(BTN_A), .BTN_B(BTN_B), .BTN_SEL(BTN_SEL), .BTN_START(BTN_START),
        .BTN_DPAD_RIGHT(BTN_DPAD_RIGHT), .BTN_DPAD_LEFT(BTN_DPAD_LEFT),
        .BTN_DPAD_UP(BTN_DPAD_UP), .BTN_DPAD_DOWN(BTN_DPAD_DOWN),
        .BTN_MENU(BTN_MENU), .scan_done(scan_done)
    );

    assign btns = {BTN_MENU, BTN_DPAD_DOWN, BTN_DPAD_UP, BTN_DPAD_LEFT, BTN_DPAD_RIGHT,
                   BTN_START, BTN_SEL, BTN_B, BTN_A};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cycle n is the period following the n-th rising edge after reset release.
    int cyc;
    always @(posedge pclk or negedge reset_n) begin
        if (!reset_n) cyc <= -1;
        else          cyc <= cyc + 1;
    end

    // External chain: parallel word (0 = pressed), bit 0 shifted out first.
    logic [NBITS-1:0] chain_word;
    logic [NBITS-1:0] sr = '1;
    assign BTN_SR_DATA = sr[0];

    // Monitor and reference model: a button flips once the last DS scan
    // samples all disagree with its current level.
    logic [8:0]       m_out;
    logic [8:0]       hist[$];
    logic [NBITS-1:0] loaded;
    logic             sclk_prev = 1'b0;
    logic             flip;
    bit               first_done;
    int               sclk_rises, ld_low, last_done;

    always @(negedge pclk) begin
        if (!BTN_SR_LD_N)                  sr = chain_word;
        else if (BTN_SR_CLK && !sclk_prev) sr = {1'b1, sr[NBITS-1:1]};
        if (!reset_n) begin
            m_out = '0;
            hist.delete();
            first_done = 1'b1;
            sclk_rises = 0;
            ld_low = 0;
        end else begin
            if (!BTN_SR_LD_N) begin
                loaded = chain_word;
                ld_low++;
            end
            if (BTN_SR_CLK && !sclk_prev) sclk_rises++;
            if (scan_done) begin
                hist.push_back(~loaded[8:0]);
                if (hist.size() >= DS) begin
                    for (int b = 0; b < 9; b++) begin
                        flip = 1'b1;
                        for (int j = 1; j <= DS; j++)
                            if (hist[hist.size() - j][b] == m_out[b]) flip = 1'b0;
                        if (flip) m_out[b] = ~m_out[b];
                    end
                end
                chk("model_btns", int'(btns), int'(m_out));
                chk("sclk_rises_per_scan", sclk_rises, NBITS - 1);
                chk("ld_n_low_cycles", ld_low, CLK_DIV);
                if (first_done) chk("first_done_cycle", cyc, FIRST_DONE);
                else            chk("scan_period", cyc - last_done, PERIOD);
                first_done = 1'b0;
                last_done = cyc;
                sclk_rises = 0;
                ld_low = 0;
            end else if (cyc % 64 == 0) begin
                chk("btns_stable", int'(btns), int'(m_out));
            end
        end
        sclk_prev = BTN_SR_CLK;
    end

    function automatic logic [NBITS-1:0] mkword(input logic [8:0] pressed);
        logic [NBITS-1:0] w;
        w = '1;
        w[8:0] = ~pressed;
        w[NBITS-1:9] = UW'($urandom);
        return w;
    endfunction

    task automatic wait_done();
        int n = 0;
        @(negedge pclk);
        while (!scan_done && n < 3000) begin
            @(negedge pclk);
            n++;
        end
        chk("scan_done_wait", int'(scan_done), 1);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    vec_t       tbl[21];
    logic [8:0] p;

    initial begin
        tbl[0]  = '{PA, 9'h000};
        tbl[1]  = '{PA, 9'h000};
        tbl[2]  = '{PA, 9'h000};
        tbl[3]  = '{PA, PA};
        tbl[4]  = '{PA | PUP, PA};
        tbl[5]  = '{PA | PUP, PA};
        tbl[6]  = '{PA | PUP, PA};
        tbl[7]  = '{PA, PA};
        tbl[8]  = '{PA | PUP, PA};
        tbl[9]  = '{PUP, PA};
        tbl[10] = '{PUP, PA};
        tbl[11] = '{PUP, PUP | PA};
        tbl[12] = '{PUP, PUP};
        tbl[13] = '{PUP | PA | PST | PMN, PUP};
        tbl[14] = '{PUP | PA | PST | PMN, PUP};
        tbl[15] = '{PUP | PA | PST | PMN, PUP};
        tbl[16] = '{PUP | PA | PST | PMN, PUP | PA | PST | PMN};
        tbl[17] = '{9'h000, PUP | PA | PST | PMN};
        tbl[18] = '{9'h000, PUP | PA | PST | PMN};
        tbl[19] = '{9'h000, PUP | PA | PST | PMN};
        tbl[20] = '{9'h000, 9'h000};

        reset_n = 1'b0;
        chain_word = mkword(tbl[0].pressed);
        repeat (3) @(negedge pclk);
        chk("rst_ld_n", int'(BTN_SR_LD_N), 1);
        chk("rst_sclk", int'(BTN_SR_CLK), 0);
        chk("rst_btns", int'(btns), 0);
        chk("rst_scan_done", int'(scan_done), 0);
        reset_n = 1'b1;
        @(posedge pclk);
        #1;
        chk("cyc0_ld_n", int'(BTN_SR_LD_N), 0);
        chk("cyc0_index", cyc, 0);

        for (int i = 0; i < 21; i++) begin
            if (i > 0) chain_word = mkword(tbl[i].pressed);
            wait_done();
            chk($sformatf("vec%0d", i), int'(btns), int'(tbl[i].exp));
        end

        // B held for four scans, then reset pulsed while SCLK is high.
        for (int i = 0; i < 4; i++) begin
            chain_word = mkword(PB);
            wait_done();
            chk($sformatf("b_scan%0d", i), int'(BTN_B), (i == 3) ? 1 : 0);
        end
        begin
            int n = 0;
            while (!BTN_SR_CLK && n < 3000) begin
                @(negedge pclk);
                n++;
            end
        end
        chk("sclk_hi_wait", int'(BTN_SR_CLK), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_btn_b", int'(BTN_B), 0);
        chk("midrst_ld_n", int'(BTN_SR_LD_N), 1);
        chk("midrst_sclk", int'(BTN_SR_CLK), 0);
        chk("midrst_btns", int'(btns), 0);
        repeat (2) @(negedge pclk);
        reset_n = 1'b1;
        @(posedge pclk);
        #1;
        chk("rel_cyc0_ld_n", int'(BTN_SR_LD_N), 0);
        chk("rel_cyc0_index", cyc, 0);
        for (int i = 0; i < 4; i++) begin
            chain_word = mkword(PB);
            wait_done();
            chk($sformatf("b_after_rst%0d", i), int'(BTN_B), (i == 3) ? 1 : 0);
        end

        // Random sticky presses; the model in the monitor does the checking.
        p = PB;
        for (int i = 0; i < 10; i++) begin
            p = p ^ (9'($urandom) & 9'($urandom));
            chain_word = mkword(p);
            wait_done();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
